pico_sim: RTL and testbench

// Stream-attached short-read matcher between one host stream channel and reference memory.
// Per job: take a 128-bit header and a 128-bit query (<=64 2-bit bases) from the input stream.

---
 rtl/pico_sim_pkg.sv | 31 +++
 rtl/pico_sim_if.sv | 25 ++
 rtl/pico_sim_fifo.sv | 46 ++++
 rtl/pico_sim.sv | 142 ++++++++++++++
 tb/tb_pico_sim.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/pico_sim_pkg.sv
// Shared types and constants for the pico_sim short-read matcher.
// Header layout, record layout, terminator marker and the control FSM states.
package pico_sim_pkg;

  localparam int HDR_NWORDS_LSB = 0;
  localparam int HDR_QLAST_LSB  = 64;
  localparam int HDR_THRESH_LSB = 96;
  localparam logic [31:0] TERM_LOC = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_HDR  = 2'd0,
    ST_QRY  = 2'd1,
    ST_SCAN = 2'd2,
    ST_TERM = 2'd3
  } state_e;

  typedef struct packed {
    logic [79:0] pad;
    logic [15:0] qid;
    logic [31:0] loc;
  } rec_t;

  function automatic logic [127:0] make_rec(input logic [15:0] qid, input logic [31:0] loc);
    rec_t r;
    r.pad = '0;
    r.qid = qid;
    r.loc = loc;
    return r;
  endfunction

endpackage

// File: rtl/pico_sim_if.sv
// Host stream in/out plus reference-memory read port of one pico_sim instance.
// Every channel transfers on a cycle where valid and ready are both high.
interface pico_sim_if;
  logic         si_valid;
  logic         si_rdy;
  logic [127:0] si_data;
  logic         so_valid;
  logic         so_rdy;
  logic [127:0] so_data;
  logic         mem_req_valid;
  logic         mem_req_ready;
  logic [31:0]  mem_req_addr;
  logic         mem_rsp_valid;
  logic [255:0] mem_rsp_data;

  modport master (
    output si_valid, si_data, so_rdy, mem_req_ready, mem_rsp_valid, mem_rsp_data,
    input  si_rdy, so_valid, so_data, mem_req_valid, mem_req_addr
  );

  modport slave (
    input  si_valid, si_data, so_rdy, mem_req_ready, mem_rsp_valid, mem_rsp_data,
    output si_rdy, so_valid, so_data, mem_req_valid, mem_req_addr
  );
endinterface

// File: rtl/pico_sim_fifo.sv
// Synchronous result FIFO; pushes are ignored while full, pops while empty.
// Read data is forced to zero when empty so the output bus is clean after reset.
module pico_sim_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 128
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = (AW+1)'(1);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_q, wr_d, rd_q, rd_d;
  logic         do_push, do_pop;

  always_comb begin
    empty   = (wr_q == rd_q);
    full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    do_push = push && !full;
    do_pop  = pop && !empty;
    wr_d    = do_push ? wr_q + ONE : wr_q;
    rd_d    = do_pop ? rd_q + ONE : rd_q;
    rd_data = empty ? '0 : mem_q[rd_q[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= push_data;
  end
endmodule

// File: rtl/pico_sim.sv
// Short-read matcher: slides the query over the streamed-in reference one base per
// cycle and emits one record per window scoring at or above the job threshold.
module pico_sim import pico_sim_pkg::*; #(
  parameter logic [31:0] REF_BASE_ADDR  = 32'h0,
  parameter int          OUT_FIFO_DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  pico_sim_if.slave  bus,
  output state_e     dbg_state
);
  state_e        state_q, state_d;
  logic [31:0]   nwords_q, nwords_d, thresh_q, thresh_d;
  logic [5:0]    qlast_q, qlast_d;
  logic [127:0]  query_q, query_d, s_q, s_d;
  logic [15:0]   qid_q, qid_d;
  logic [38:0]   j_q, j_d;
  logic [31:0]   req_cnt_q, req_cnt_d, eval_loc_q, eval_loc_d;
  logic          out_q, out_d, pre_vld_q, pre_vld_d, cur_vld_q, cur_vld_d;
  logic          eval_vld_q, eval_vld_d;
  logic [255:0]  pre_q, pre_d, cur_q, cur_d;
  logic [6:0]    bidx_q, bidx_d;

  logic          push, full, empty, hit, req_valid;
  logic [127:0]  push_data;
  logic [6:0]    match_cnt;
  logic [7:0]    score;
  logic [5:0]    k;
  logic [38:0]   total;

  pico_sim_fifo #(.DEPTH(OUT_FIFO_DEPTH), .W(128)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .push_data(push_data),
    .pop(bus.so_rdy), .rd_data(bus.so_data), .full(full), .empty(empty)
  );

  assign bus.so_valid      = !empty;
  assign bus.si_rdy        = !rst && (state_q == ST_HDR || state_q == ST_QRY);
  assign bus.mem_req_valid = req_valid;
  assign bus.mem_req_addr  = req_valid ? REF_BASE_ADDR + {req_cnt_q[26:0], 5'b0} : '0;
  assign dbg_state         = state_q;
  assign total             = {nwords_q, 7'b0};

  // Window score: S[63] holds the newest base, so the window starts at S[63-qlast].
  always_comb begin
    match_cnt = '0;
    k         = '0;
    for (int i = 0; i < 64; i++) begin
      k = 6'(63 - int'(qlast_q) + i);
      if (6'(i) <= qlast_q && query_q[2*i +: 2] == s_q[2*k +: 2])
        match_cnt = match_cnt + 7'd1;
    end
    score = {match_cnt, 1'b0};
    hit   = {24'h0, score} >= thresh_q;
  end

  always_comb begin
    state_d = state_q;    nwords_d = nwords_q;   thresh_d = thresh_q;
    qlast_d = qlast_q;    query_d = query_q;     s_d = s_q;
    qid_d = qid_q;        j_d = j_q;             req_cnt_d = req_cnt_q;
    out_d = out_q;        pre_d = pre_q;         pre_vld_d = pre_vld_q;
    cur_d = cur_q;        cur_vld_d = cur_vld_q; bidx_d = bidx_q;
    eval_vld_d = eval_vld_q; eval_loc_d = eval_loc_q;
    push = 1'b0;
    push_data = '0;
    req_valid = (state_q == ST_SCAN) && !out_q && !pre_vld_q && (req_cnt_q < nwords_q);

    if (req_valid && bus.mem_req_ready) begin
      out_d     = 1'b1;
      req_cnt_d = req_cnt_q + 32'd1;
    end
    if (!cur_vld_q && pre_vld_q) begin
      cur_d     = pre_q;
      cur_vld_d = 1'b1;
      pre_vld_d = 1'b0;
    end
    if (bus.mem_rsp_valid && out_q) begin
      pre_d     = bus.mem_rsp_data;
      pre_vld_d = 1'b1;
      out_d     = 1'b0;
    end

    case (state_q)
      ST_HDR: if (bus.si_valid) begin
        nwords_d = bus.si_data[HDR_NWORDS_LSB +: 32];
        thresh_d = bus.si_data[HDR_THRESH_LSB +: 32];
        qlast_d  = (bus.si_data[HDR_QLAST_LSB +: 32] > 32'd63) ? 6'd63
                                                               : bus.si_data[HDR_QLAST_LSB +: 6];
        state_d  = ST_QRY;
      end
      ST_QRY: if (bus.si_valid) begin
        query_d    = bus.si_data;
        j_d        = '0;
        req_cnt_d  = '0;
        bidx_d     = '0;
        eval_vld_d = 1'b0;
        cur_vld_d  = 1'b0;
        pre_vld_d  = 1'b0;
        state_d    = ST_SCAN;
      end
      ST_SCAN: if (!full) begin
        if (eval_vld_q) begin
          push       = hit;
          push_data  = make_rec(qid_q, eval_loc_q);
          eval_vld_d = 1'b0;
        end
        if (j_q == total) begin
          state_d = ST_TERM;
        end else if (cur_vld_q) begin
          s_d        = {cur_q[2*bidx_q +: 2], s_q[127:2]};
          eval_vld_d = (j_q >= {33'h0, qlast_q});
          eval_loc_d = 32'(j_q - {33'h0, qlast_q});
          j_d        = j_q + 39'd1;
          bidx_d     = bidx_q + 7'd1;
          if (bidx_q == 7'd127) cur_vld_d = 1'b0;
        end
      end
      ST_TERM: if (!full) begin
        push      = 1'b1;
        push_data = make_rec(qid_q, TERM_LOC);
        qid_d     = qid_q + 16'd1;
        state_d   = ST_HDR;
      end
      default: state_d = ST_HDR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_HDR;  nwords_q <= '0;  thresh_q <= '0;  qlast_q <= '0;
      query_q <= '0;      s_q <= '0;       qid_q <= '0;     j_q <= '0;
      req_cnt_q <= '0;    out_q <= 1'b0;   pre_q <= '0;     pre_vld_q <= 1'b0;
      cur_q <= '0;        cur_vld_q <= 1'b0; bidx_q <= '0;
      eval_vld_q <= 1'b0; eval_loc_q <= '0;
    end else begin
      state_q <= state_d;  nwords_q <= nwords_d;  thresh_q <= thresh_d;  qlast_q <= qlast_d;
      query_q <= query_d;  s_q <= s_d;            qid_q <= qid_d;        j_q <= j_d;
      req_cnt_q <= req_cnt_d; out_q <= out_d;     pre_q <= pre_d;        pre_vld_q <= pre_vld_d;
      cur_q <= cur_d;      cur_vld_q <= cur_vld_d; bidx_q <= bidx_d;
      eval_vld_q <= eval_vld_d; eval_loc_q <= eval_loc_d;
    end
  end
endmodule

// File: tb/tb_pico_sim.sv
// Directed bench for pico_sim: reference memory responder, stream driver tasks,
// expected-record queue per job and a final one-line report.
module tb_pico_sim;
  import pico_sim_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pico_sim_if bus();
  state_e dbg_state;

  pico_sim #(.REF_BASE_ADDR(32'h0), .OUT_FIFO_DEPTH(16)) dut (
    .clk(clk), .rst(rst), .bus(bus), .dbg_state(dbg_state)
  );

  int errors = 0;
  int checks = 0;
  logic [127:0] exp_q[$];
  logic [127:0] got_q[$];

  logic [255:0] ref_words [8];
  logic         ref_zero  = 1'b0;
  int           mem_lat   = 0;
  int           proto_err = 0;
  int           req_total = 0;
  logic [31:0]  mem_addr  = '0;

  localparam logic [127:0] HDR_A  = 128'h0000007E_0000003F_00000000_00000008;
  localparam logic [127:0] HDR_AH = 128'h00000081_0000003F_00000000_00000008;
  localparam logic [127:0] QRY_A  = 128'hc8facaa7c280aa28a020aaaf89aae004;
  localparam logic [127:0] HDR_Z  = 128'h00000008_00000003_00000000_00000001;
  localparam logic [127:0] HDR_N0 = 128'h00000000_00000000_00000000_00000000;
  localparam logic [127:0] HDR_CL = 128'h00000080_000000FF_00000000_00000001;

  // Memory responder: data two cycles after each accepted request.
  always @(negedge clk) begin
    if (rst) begin
      bus.mem_rsp_valid = 1'b0;
      bus.mem_rsp_data  = '0;
      bus.mem_req_ready = 1'b0;
      mem_lat = 0;
    end else begin
      bus.mem_rsp_valid = 1'b0;
      if (mem_lat > 0) begin
        mem_lat--;
        if (mem_lat == 0) begin
          bus.mem_rsp_valid = 1'b1;
          bus.mem_rsp_data  = ref_zero ? '0 : ref_words[mem_addr[7:5]];
        end
      end
      bus.mem_req_ready = ($urandom_range(0, 3) != 0);
      if (bus.mem_req_valid && bus.mem_req_ready) begin
        if (mem_lat != 0 || bus.mem_req_addr[4:0] != 5'd0) proto_err++;
        if (!ref_zero && bus.mem_req_addr > 32'd224) proto_err++;
        mem_lat  = 2;
        mem_addr = bus.mem_req_addr;
        req_total++;
      end
    end
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send_word(input string tag, input logic [127:0] w);
    int n = 0;
    @(negedge clk);
    bus.si_valid = 1'b1;
    bus.si_data  = w;
    while (!bus.si_rdy && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_accept"}, 128'(bus.si_rdy), 128'd1);
    @(negedge clk);
    bus.si_valid = 1'b0;
  endtask

  task automatic collect(input string tag, input bit rand_rdy);
    int   n    = 0;
    logic done = 1'b0;
    got_q.delete();
    while (!done && n < 20000) begin
      @(negedge clk);
      n++;
      bus.so_rdy = rand_rdy ? ($urandom_range(0, 1) == 1) : 1'b1;
      if (bus.so_valid && bus.so_rdy) begin
        got_q.push_back(bus.so_data);
        if (bus.so_data[31:0] == TERM_LOC) done = 1'b1;
      end
    end
    @(negedge clk);
    bus.so_rdy = 1'b0;
    check({tag, "_terminated"}, 128'(done), 128'd1);
  endtask

  task automatic compare(input string tag);
    check({tag, "_count"}, 128'(got_q.size()), 128'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s_rec%0d", tag, i), got_q[i], exp_q[i]);
    exp_q.delete();
  endtask

  task automatic run_job(input string tag, input logic [127:0] hdr,
                         input logic [127:0] qry, input bit rand_rdy);
    send_word({tag, "_hdr"}, hdr);
    send_word({tag, "_qry"}, qry);
    collect(tag, rand_rdy);
    compare(tag);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_so_valid"},  128'(bus.so_valid), 128'd0);
    check({tag, "_so_data"},   bus.so_data, 128'd0);
    check({tag, "_si_rdy"},    128'(bus.si_rdy), 128'd0);
    check({tag, "_req_valid"}, 128'(bus.mem_req_valid), 128'd0);
    check({tag, "_req_addr"},  128'(bus.mem_req_addr), 128'd0);
    check({tag, "_state"},     128'(dbg_state), 128'(ST_HDR));
  endtask

  initial begin
    int reqs_before;
    bus.si_valid = 1'b0;
    bus.si_data  = '0;
    bus.so_rdy   = 1'b0;
    ref_words[0] = 256'he389b65d283e6a2114be2ea9ac13a2c51a5ae0cac686a7f902290ac9ec471910;
    ref_words[1] = 256'h280aa28a020aaaf89aae0044813909030b2f804401e10a661972c5e8e183b808;
    ref_words[2] = 256'h854220248394972a8c42fa566fc68a843191be33900c214033ba207c8facaa7c;
    ref_words[3] = 256'h0a190931a2959ca240023f566b89f02a83c42b8c9e0a9a84000908c99090aa46;
    ref_words[4] = 256'h4640aaeeeefee8cccccccccccccccf1a113126a997296ac83a8a2fa9a02cf2bb;
    ref_words[5] = 256'h88aa68aae229a2aaea891050240501c214440411c14050140040108e644a8945;
    ref_words[6] = 256'h9ba26088eea2a4233980226062232c72ee110f3a94825caa160fa08a001693cb;
    ref_words[7] = 256'h80827101560a04ac8f0090d87ca21348c4a85a9a4c1bc6029a093006968c0148;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);
    check("idle_si_rdy", 128'(bus.si_rdy), 128'd1);

    // Reference match at loc 210, run twice to see qid advance.
    exp_q.push_back(make_rec(16'd0, 32'd210));
    exp_q.push_back(make_rec(16'd0, TERM_LOC));
    run_job("job_a0", HDR_A, QRY_A, 1'b0);
    exp_q.push_back(make_rec(16'd1, 32'd210));
    exp_q.push_back(make_rec(16'd1, TERM_LOC));
    run_job("job_a1", HDR_A, QRY_A, 1'b0);

    // Fresh instance state, threshold above the best score.
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_q.push_back(make_rec(16'd0, TERM_LOC));
    run_job("job_hi", HDR_AH, QRY_A, 1'b0);

    // All-zero reference: every window hits, stressing FIFO backpressure.
    ref_zero = 1'b1;
    for (int i = 0; i < 125; i++) exp_q.push_back(make_rec(16'd1, 32'(i)));
    exp_q.push_back(make_rec(16'd1, TERM_LOC));
    run_job("job_z", HDR_Z, 128'h0, 1'b0);
    for (int i = 0; i < 125; i++) exp_q.push_back(make_rec(16'd2, 32'(i)));
    exp_q.push_back(make_rec(16'd2, TERM_LOC));
    run_job("job_zr", HDR_Z, 128'h0, 1'b1);

    // Empty reference: terminator only, no memory traffic.
    reqs_before = req_total;
    exp_q.push_back(make_rec(16'd3, TERM_LOC));
    run_job("job_n0", HDR_N0, 128'h0, 1'b0);
    check("n0_no_requests", 128'(req_total - reqs_before), 128'd0);

    // qlast field above 63 behaves as 63: windows at loc 0..64.
    for (int i = 0; i <= 64; i++) exp_q.push_back(make_rec(16'd4, 32'(i)));
    exp_q.push_back(make_rec(16'd4, TERM_LOC));
    run_job("job_clamp", HDR_CL, 128'h0, 1'b1);

    // Abort in the middle of a scan, then rerun cleanly.
    ref_zero = 1'b0;
    send_word("abort_hdr", HDR_A);
    send_word("abort_qry", QRY_A);
    repeat (60) @(negedge clk);
    check("abort_in_scan", 128'(dbg_state), 128'(ST_SCAN));
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("abort");
    rst = 1'b0;
    exp_q.push_back(make_rec(16'd0, 32'd210));
    exp_q.push_back(make_rec(16'd0, TERM_LOC));
    run_job("job_after", HDR_A, QRY_A, 1'b1);

    check("mem_protocol", 128'(proto_err), 128'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
